// File: rtl/vga_cfg_pkg.sv
// Shared definitions for the VGA configuration shadow stage: register map,
// 640x480 defaults, bank layout and control FSM states.
package vga_cfg_pkg;

  localparam logic [3:0] ADDR_H_SYNC     = 4'd0;
  localparam logic [3:0] ADDR_H_BP       = 4'd1;
  localparam logic [3:0] ADDR_H_FP       = 4'd2;
  localparam logic [3:0] ADDR_H_RANGE    = 4'd3;
  localparam logic [3:0] ADDR_H_LR_BORD  = 4'd4;
  localparam logic [3:0] ADDR_V_SYNC     = 4'd5;
  localparam logic [3:0] ADDR_V_BP       = 4'd6;
  localparam logic [3:0] ADDR_V_FP       = 4'd7;
  localparam logic [3:0] ADDR_V_RANGE    = 4'd8;
  localparam logic [3:0] ADDR_V_TB_BORD  = 4'd9;
  localparam logic [3:0] ADDR_IN_COLOR   = 4'd10;
  localparam logic [3:0] ADDR_OUT_COLOR  = 4'd11;

  localparam logic [31:0] DEF_H_SYNC     = 32'd96;
  localparam logic [31:0] DEF_H_BP       = 32'd48;
  localparam logic [31:0] DEF_H_FP       = 32'd16;
  localparam logic [31:0] DEF_H_RANGE    = 32'd640;
  localparam logic [31:0] DEF_H_LR_BORD  = 32'd0;
  localparam logic [31:0] DEF_V_SYNC     = 32'd2;
  localparam logic [31:0] DEF_V_BP       = 32'd33;
  localparam logic [31:0] DEF_V_FP       = 32'd10;
  localparam logic [31:0] DEF_V_RANGE    = 32'd480;
  localparam logic [31:0] DEF_V_TB_BORD  = 32'd0;
  localparam logic [15:0] DEF_IN_COLOR   = 16'hFFFF;
  localparam logic [15:0] DEF_OUT_COLOR  = 16'h0000;

  typedef struct packed {
    logic [31:0] h_sync;
    logic [31:0] h_bp;
    logic [31:0] h_fp;
    logic [31:0] h_range;
    logic [31:0] h_lr_border;
    logic [31:0] v_sync;
    logic [31:0] v_bp;
    logic [31:0] v_fp;
    logic [31:0] v_range;
    logic [31:0] v_tb_border;
    logic [15:0] in_color;
    logic [15:0] out_color;
  } cfg_t;

  localparam cfg_t CFG_DEFAULT = '{
    h_sync:      DEF_H_SYNC,
    h_bp:        DEF_H_BP,
    h_fp:        DEF_H_FP,
    h_range:     DEF_H_RANGE,
    h_lr_border: DEF_H_LR_BORD,
    v_sync:      DEF_V_SYNC,
    v_bp:        DEF_V_BP,
    v_fp:        DEF_V_FP,
    v_range:     DEF_V_RANGE,
    v_tb_border: DEF_V_TB_BORD,
    in_color:    DEF_IN_COLOR,
    out_color:   DEF_OUT_COLOR
  };

  typedef enum logic [1:0] {
    IDLE,
    VALIDATE,
    ARMED
  } state_e;

endpackage

// File: rtl/vga_cfg_validate.sv
// Combinational sanity check of a timing set before it may be committed.
module vga_cfg_validate #(
  parameter int unsigned MAX_H_TOTAL  = 4096,
  parameter int unsigned MAX_V_TOTAL  = 2048,
  parameter int unsigned INNER_MARGIN = 50
) (
  input  logic [31:0] h_sync,
  input  logic [31:0] h_bp,
  input  logic [31:0] h_fp,
  input  logic [31:0] h_range,
  input  logic [31:0] h_lr_border,
  input  logic [31:0] v_sync,
  input  logic [31:0] v_bp,
  input  logic [31:0] v_fp,
  input  logic [31:0] v_range,
  input  logic [31:0] v_tb_border,
  output logic        pass
);

  localparam logic [34:0] MinRange = 35'(2 * INNER_MARGIN + 1);
  localparam logic [34:0] MaxH     = 35'(MAX_H_TOTAL);
  localparam logic [34:0] MaxV     = 35'(MAX_V_TOTAL);

  logic [34:0] h_total;
  logic [34:0] v_total;
  logic        zero_bad;
  logic        range_bad;
  logic        total_bad;

  // Five 32-bit terms fit in 35 bits, so the totals can never wrap.
  always_comb begin
    h_total = 35'(h_sync) + 35'(h_bp) + 35'(h_fp) + 35'(h_range) + 35'(h_lr_border);
    v_total = 35'(v_sync) + 35'(v_bp) + 35'(v_fp) + 35'(v_range) + 35'(v_tb_border);
    zero_bad  = (h_sync == '0) || (h_range == '0) || (v_sync == '0) || (v_range == '0);
    range_bad = (35'(h_range) < MinRange) || (35'(v_range) < MinRange);
    total_bad = (h_total > MaxH) || (v_total > MaxV);
    pass      = ~(zero_bad | range_bad | total_bad);
  end

endmodule

// File: rtl/vga_cfg_shadow.sv
// Shadow register bank with validate-then-commit onto the active bank,
// committing only at a vertical sync start (or on timeout) to avoid torn frames.
module vga_cfg_shadow
  import vga_cfg_pkg::*;
#(
  parameter int unsigned MAX_H_TOTAL    = 4096,
  parameter int unsigned MAX_V_TOTAL    = 2048,
  parameter int unsigned INNER_MARGIN   = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        cfg_wr_en,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        commit_req,
  input  logic        vga_vs,
  output logic        busy,
  output logic        commit_ack,
  output logic        commit_err,
  output logic        forced,
  output logic [31:0] H_Sync,
  output logic [31:0] H_BP,
  output logic [31:0] H_FP,
  output logic [31:0] H_Range,
  output logic [31:0] H_LR_Border,
  output logic [31:0] V_Sync,
  output logic [31:0] V_BP,
  output logic [31:0] V_FP,
  output logic [31:0] V_Range,
  output logic [31:0] V_TB_Border,
  output logic [15:0] InImage_Color,
  output logic [15:0] OutImage_Color
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  cfg_t            shadow_q, shadow_d;
  cfg_t            active_q, active_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            vs_prev_q;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            forced_q, forced_d;
  logic            vs_fall;
  logic            timeout_hit;
  logic            pass;

  vga_cfg_validate #(
    .MAX_H_TOTAL  (MAX_H_TOTAL),
    .MAX_V_TOTAL  (MAX_V_TOTAL),
    .INNER_MARGIN (INNER_MARGIN)
  ) u_validate (
    .h_sync      (shadow_q.h_sync),
    .h_bp        (shadow_q.h_bp),
    .h_fp        (shadow_q.h_fp),
    .h_range     (shadow_q.h_range),
    .h_lr_border (shadow_q.h_lr_border),
    .v_sync      (shadow_q.v_sync),
    .v_bp        (shadow_q.v_bp),
    .v_fp        (shadow_q.v_fp),
    .v_range     (shadow_q.v_range),
    .v_tb_border (shadow_q.v_tb_border),
    .pass        (pass)
  );

  assign vs_fall     = vs_prev_q & ~vga_vs;
  assign timeout_hit = (cnt_q == CntLast);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = '0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    forced_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_wr_en) begin
          case (cfg_addr)
            ADDR_H_SYNC:    shadow_d.h_sync      = cfg_wdata;
            ADDR_H_BP:      shadow_d.h_bp        = cfg_wdata;
            ADDR_H_FP:      shadow_d.h_fp        = cfg_wdata;
            ADDR_H_RANGE:   shadow_d.h_range     = cfg_wdata;
            ADDR_H_LR_BORD: shadow_d.h_lr_border = cfg_wdata;
            ADDR_V_SYNC:    shadow_d.v_sync      = cfg_wdata;
            ADDR_V_BP:      shadow_d.v_bp        = cfg_wdata;
            ADDR_V_FP:      shadow_d.v_fp        = cfg_wdata;
            ADDR_V_RANGE:   shadow_d.v_range     = cfg_wdata;
            ADDR_V_TB_BORD: shadow_d.v_tb_border = cfg_wdata;
            ADDR_IN_COLOR:  shadow_d.in_color    = cfg_wdata[15:0];
            ADDR_OUT_COLOR: shadow_d.out_color   = cfg_wdata[15:0];
            default: ;
          endcase
        end
        if (commit_req) state_d = VALIDATE;
      end
      VALIDATE: begin
        if (pass) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end
      end
      ARMED: begin
        // A real sync edge wins over a simultaneous timeout, hence forced = ~vs_fall.
        if (vs_fall || timeout_hit) begin
          state_d  = IDLE;
          active_d = shadow_q;
          ack_d    = 1'b1;
          forced_d = ~vs_fall;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= CFG_DEFAULT;
      active_q  <= CFG_DEFAULT;
      cnt_q     <= '0;
      vs_prev_q <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      forced_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      vs_prev_q <= vga_vs;
      ack_q     <= ack_d;
      err_q     <= err_d;
      forced_q  <= forced_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign commit_ack     = ack_q;
  assign commit_err     = err_q;
  assign forced         = forced_q;
  assign H_Sync         = active_q.h_sync;
  assign H_BP           = active_q.h_bp;
  assign H_FP           = active_q.h_fp;
  assign H_Range        = active_q.h_range;
  assign H_LR_Border    = active_q.h_lr_border;
  assign V_Sync         = active_q.v_sync;
  assign V_BP           = active_q.v_bp;
  assign V_FP           = active_q.v_fp;
  assign V_Range        = active_q.v_range;
  assign V_TB_Border    = active_q.v_tb_border;
  assign InImage_Color  = active_q.in_color;
  assign OutImage_Color = active_q.out_color;

endmodule

// File: tb/tb_vga_cfg_shadow.sv
// Directed bench for vga_cfg_shadow: commit on sync edge, rejects, timeout, ignored traffic.
module tb_vga_cfg_shadow;

  logic        pixel_clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        commit_req = 1'b0;
  logic        vga_vs = 1'b1;
  logic        busy, commit_ack, commit_err, forced;
  logic [31:0] H_Sync, H_BP, H_FP, H_Range, H_LR_Border;
  logic [31:0] V_Sync, V_BP, V_FP, V_Range, V_TB_Border;
  logic [15:0] InImage_Color, OutImage_Color;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_cfg_shadow #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pixel_clk      (pixel_clk),
    .reset          (reset),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .commit_req     (commit_req),
    .vga_vs         (vga_vs),
    .busy           (busy),
    .commit_ack     (commit_ack),
    .commit_err     (commit_err),
    .forced         (forced),
    .H_Sync         (H_Sync),
    .H_BP           (H_BP),
    .H_FP           (H_FP),
    .H_Range        (H_Range),
    .H_LR_Border    (H_LR_Border),
    .V_Sync         (V_Sync),
    .V_BP           (V_BP),
    .V_FP           (V_FP),
    .V_Range        (V_Range),
    .V_TB_Border    (V_TB_Border),
    .InImage_Color  (InImage_Color),
    .OutImage_Color (OutImage_Color)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs read there reflect that edge.
  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  // Pulse commit_req and expect a reject ack two cycles later.
  task automatic expect_reject(input string tag, input logic [31:0] h_range_exp);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_noack"}, 32'(commit_ack), 32'd0);
    tick();
    check_eq({tag, "_ack"}, 32'(commit_ack), 32'd1);
    check_eq({tag, "_err"}, 32'(commit_err), 32'd1);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_hrange"}, H_Range, h_range_exp);
    tick();
    check_eq({tag, "_ackclr"}, 32'(commit_ack), 32'd0);
  endtask

  initial begin
    int n;
    bit seen_busy_drop;

    // Reset and idle defaults
    vga_vs = 1'b1;
    reset  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_eq("rst_hsync", H_Sync, 32'd96);
    check_eq("rst_hbp", H_BP, 32'd48);
    check_eq("rst_hfp", H_FP, 32'd16);
    check_eq("rst_hrange", H_Range, 32'd640);
    check_eq("rst_vsync", V_Sync, 32'd2);
    check_eq("rst_vbp", V_BP, 32'd33);
    check_eq("rst_vrange", V_Range, 32'd480);
    check_eq("rst_in", 32'(InImage_Color), 32'h0000FFFF);
    check_eq("rst_out", 32'(OutImage_Color), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ack", 32'(commit_ack), 32'd0);

    // Normal commit on a vga_vs falling edge; write and commit_req in the same cycle
    cfg_write(4'd3, 32'd800);
    cfg_wr_en  = 1'b1;
    cfg_addr   = 4'd8;
    cfg_wdata  = 32'd600;
    commit_req = 1'b1;
    tick();
    cfg_wr_en  = 1'b0;
    commit_req = 1'b0;
    check_eq("c1_busy_t1", 32'(busy), 32'd1);
    seen_busy_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!busy || commit_ack) seen_busy_drop = 1'b1;
    end
    check_eq("c1_busy_wait", 32'(seen_busy_drop), 32'd0);
    check_eq("c1_hold_hrange", H_Range, 32'd640);
    vga_vs = 1'b0;
    tick();
    check_eq("c1_hrange", H_Range, 32'd800);
    check_eq("c1_vrange", V_Range, 32'd600);
    check_eq("c1_ack", 32'(commit_ack), 32'd1);
    check_eq("c1_err", 32'(commit_err), 32'd0);
    check_eq("c1_forced", 32'(forced), 32'd0);
    check_eq("c1_busy", 32'(busy), 32'd0);
    vga_vs = 1'b1;
    tick();
    check_eq("c1_ackclr", 32'(commit_ack), 32'd0);

    // Rejects: range below 2*50+1, H total overflow, zero sync
    cfg_write(4'd3, 32'd100);
    expect_reject("rj_range", 32'd800);
    cfg_write(4'd3, 32'd800);
    cfg_write(4'd2, 32'd4000);
    expect_reject("rj_htot", 32'd800);
    cfg_write(4'd2, 32'd16);
    cfg_write(4'd0, 32'd0);
    expect_reject("rj_hsync0", 32'd800);
    cfg_write(4'd0, 32'd96);
    // H total 96+48+3852+100+0 = 4096 is legal, 101 range with 3853 FP gives 4098
    cfg_write(4'd3, 32'd101);
    cfg_write(4'd2, 32'd3853);
    expect_reject("rj_htot4098", 32'd800);
    cfg_write(4'd2, 32'd3851);
    cfg_write(4'd8, 32'd101);

    // Timeout commit with vga_vs idle high; exact boundaries H total 4096, ranges 101
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!commit_ack && n < 100);
    check_eq("to_cycles", 32'(n), 32'd17);
    check_eq("to_ack", 32'(commit_ack), 32'd1);
    check_eq("to_forced", 32'(forced), 32'd1);
    check_eq("to_err", 32'(commit_err), 32'd0);
    check_eq("to_hrange", H_Range, 32'd101);
    check_eq("to_hfp", H_FP, 32'd3851);
    check_eq("to_vrange", V_Range, 32'd101);
    tick();
    check_eq("to_forcedclr", 32'(forced), 32'd0);

    // Writes and commit_req while ARMED are dropped
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    cfg_write(4'd10, 32'h1234);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    vga_vs = 1'b0;
    tick();
    check_eq("ig_ack", 32'(commit_ack), 32'd1);
    check_eq("ig_in", 32'(InImage_Color), 32'h0000FFFF);
    vga_vs = 1'b1;
    tick();
    check_eq("ig_noack", 32'(commit_ack), 32'd0);
    check_eq("ig_idle", 32'(busy), 32'd0);

    // Reset while ARMED aborts silently and restores defaults
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    tick();
    check_eq("ra_armed", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check_eq("ra_hrange", H_Range, 32'd640);
    check_eq("ra_hfp", H_FP, 32'd16);
    check_eq("ra_vrange", V_Range, 32'd480);
    check_eq("ra_ack", 32'(commit_ack), 32'd0);
    check_eq("ra_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) begin
      tick();
      if (commit_ack) check_eq("ra_late_ack", 32'(commit_ack), 32'd0);
    end
    check_eq("ra_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
